// File: rtl/qc_ldpc_pkg.sv
// qc_ldpc_pkg: shared types, width helpers and the circulant rotate function
// for the QC-LDPC encoder datapath.
package qc_ldpc_pkg;

    localparam int MAX_Z = 1024;

    typedef logic [MAX_Z-1:0] zword_t;

    typedef enum logic {IDLE, ACCUM} row_state_t;

    function automatic int shift_w(input int z);
        return (z > 2) ? $clog2(z) : 1;
    endfunction

    function automatic int beat_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // Right-rotate the low z bits of data by shift (shift < z), upper bits zero.
    function automatic zword_t rotr_z(input zword_t data, input int unsigned shift, input int unsigned z);
        logic [2*MAX_Z-1:0] dd;
        zword_t             mask;
        mask = (z >= MAX_Z) ? '1 : ((zword_t'(1) << z) - zword_t'(1));
        dd   = {{MAX_Z{1'b0}}, data & mask};
        dd   = dd | (dd << z);
        return zword_t'(dd >> shift) & mask;
    endfunction

endpackage

// File: rtl/qc_lane_rotate.sv
// qc_lane_rotate: one lane's circulant contribution with null and shift-range
// handling; out-of-range shifts contribute zero and raise o_bad_shift.
module qc_lane_rotate
    import qc_ldpc_pkg::*;
#(
    parameter int Z   = 81,
    parameter int SHW = shift_w(Z)
) (
    input  logic [Z-1:0]   i_data,
    input  logic [SHW-1:0] i_shift,
    input  logic           i_null,
    output logic [Z-1:0]   o_contrib,
    output logic           o_bad_shift
);

    logic         w_bad;
    logic [Z-1:0] w_rot;

    assign w_bad       = 32'(i_shift) >= Z;
    assign w_rot       = Z'(rotr_z(zword_t'(i_data), 32'(i_shift), Z));
    assign o_contrib   = (i_null || w_bad) ? '0 : w_rot;
    assign o_bad_shift = !i_null && w_bad;

endmodule

// File: rtl/qc_rotate_accumulate.sv
// qc_rotate_accumulate: multi-lane circulant rotate, XOR-reduce and per-row
// accumulate, emitting one Z-bit parity word per prototype row.
module qc_rotate_accumulate
    import qc_ldpc_pkg::*;
#(
    parameter int Z         = 81,
    parameter int LANES     = 4,
    parameter int MAX_BEATS = 24,
    parameter int SHW       = shift_w(Z),
    parameter int BCW       = beat_w(MAX_BEATS)
) (
    input  logic                 i_sysclk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [LANES*Z-1:0]   i_s_data,
    input  logic [LANES*SHW-1:0] i_s_shift,
    input  logic [LANES-1:0]     i_s_null,
    input  logic                 i_s_last,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [Z-1:0]         o_m_data,
    output logic [BCW-1:0]       o_m_beats,
    output logic                 o_err_shift,
    output logic                 o_err_len
);

    logic [Z-1:0]     w_contrib [LANES];
    logic [LANES-1:0] w_bad;
    logic [Z-1:0]     w_xor;
    logic [Z-1:0]     w_sum;
    logic             w_en;
    logic             w_accept;
    logic             w_fold;
    logic             w_close;
    row_state_t       w_next;

    row_state_t       r_state;
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [Z-1:0]     r_s1_data;
    logic [Z-1:0]     r_acc;
    logic [BCW-1:0]   r_cnt;
    logic             r_m_valid;
    logic [Z-1:0]     r_m_data;
    logic [BCW-1:0]   r_m_beats;
    logic             r_err_shift;
    logic             r_err_len;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        qc_lane_rotate #(.Z(Z), .SHW(SHW)) u_rot (
            .i_data      (i_s_data[l*Z +: Z]),
            .i_shift     (i_s_shift[l*SHW +: SHW]),
            .i_null      (i_s_null[l]),
            .o_contrib   (w_contrib[l]),
            .o_bad_shift (w_bad[l])
        );
    end

    always_comb begin
        w_xor = '0;
        for (int i = 0; i < LANES; i++) w_xor = w_xor ^ w_contrib[i];
    end

    // A stalled output word freezes the whole pipeline.
    assign w_en      = !(r_m_valid && !i_m_ready);
    assign o_s_ready = i_rst_n && w_en && !i_clr;
    assign w_accept  = i_s_valid && o_s_ready;
    assign w_fold    = w_en && r_s1_valid;
    assign w_close   = w_fold && (r_s1_last || r_cnt == BCW'(MAX_BEATS - 1));
    assign w_sum     = ((r_state == ACCUM) ? r_acc : '0) ^ r_s1_data;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? ((w_fold && !w_close) ? ACCUM : IDLE) : (w_close ? IDLE : ACCUM);
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n)   r_state <= IDLE;
        else if (i_clr) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_data   <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_beats   <= '0;
            r_err_shift <= 1'b0;
            r_err_len   <= 1'b0;
        end else if (i_clr) begin
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            if (w_en) begin
                r_s1_valid <= w_accept;
                r_s1_last  <= i_s_last;
                r_s1_data  <= w_xor;
            end
            if (w_fold) begin
                r_acc <= w_close ? '0 : w_sum;
                r_cnt <= w_close ? '0 : r_cnt + 1'b1;
            end
            if (w_close) begin
                r_m_data  <= w_sum;
                r_m_beats <= r_cnt + 1'b1;
            end
            r_m_valid   <= w_close || (r_m_valid && !i_m_ready);
            r_err_shift <= r_err_shift || (w_accept && |w_bad);
            // A close without s_last is a forced close at MAX_BEATS.
            r_err_len   <= r_err_len || (w_close && !r_s1_last);
        end
    end

    assign o_m_valid   = r_m_valid;
    assign o_m_data    = r_m_data;
    assign o_m_beats   = r_m_beats;
    assign o_err_shift = r_err_shift;
    assign o_err_len   = r_err_len;

endmodule
